// File: rtl/aes_round_ctrl.sv
// AES-128 encryption sequencer: owns the cipher state and walks it through the
// SubBytes/ShiftRows/MixColumns/AddRoundKey units using their En/Ry handshakes.
module aes_round_ctrl #(
    parameter int unsigned TO_CYC = 255
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [127:0] Pt_In,
    input  logic [127:0] Rk_In,
    output logic [3:0]   Round,
    output logic [127:0] St_Out,
    output logic [127:0] Rk_ARK,
    output logic         En_SBT,
    output logic         En_SRW,
    output logic         En_MXC,
    output logic         En_ARK,
    input  logic         Ry_SBT,
    input  logic         Ry_SRW,
    input  logic         Ry_MXC,
    input  logic         Ry_ARK,
    input  logic [127:0] Out_SBT,
    input  logic [127:0] Out_SRW,
    input  logic [127:0] Out_MXC,
    input  logic [127:0] Out_ARK,
    output logic [127:0] Ct_Out,
    output logic         Busy,
    output logic         Done,
    output logic         Err
);

    localparam int unsigned DW         = 128;
    localparam int unsigned RW         = 4;
    localparam int unsigned CW         = 8;
    localparam int unsigned NU         = 4;
    localparam int unsigned LAST_ROUND = 10;

    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_RELEASE, ST_FIN, ST_ERR} state_t;
    typedef enum logic [2:0] {STEP_ARK0, STEP_SBT, STEP_SRW, STEP_MXC, STEP_ARK} step_t;

    state_t          state_q, state_d;
    step_t           step_q, step_d, step_nxt_c;
    logic            fin_nxt_c;
    logic            ry_sel_c;
    logic            to_hit_c;
    logic [DW-1:0]   res_sel_c;
    logic [RW-1:0]   round_d;
    logic [DW-1:0]   st_d, rk_d, ct_d;
    logic [NU-1:0]   en_q, en_d;
    logic            busy_d, done_d, err_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;

    // Unit enable bit for a step: {ARK, MXC, SRW, SBT}
    function automatic logic [NU-1:0] en_of(input step_t s);
        case (s)
            STEP_SBT: return 4'b0001;
            STEP_SRW: return 4'b0010;
            STEP_MXC: return 4'b0100;
            default:  return 4'b1000;
        endcase
    endfunction

    function automatic logic is_ark(input step_t s);
        return (s == STEP_ARK0) || (s == STEP_ARK);
    endfunction

    assign En_SBT   = en_q[0];
    assign En_SRW   = en_q[1];
    assign En_MXC   = en_q[2];
    assign En_ARK   = en_q[3];
    assign to_hit_c = (wcnt_q == CW'(TO_CYC - 1));

    // Handshake and result of the unit owned by the current step only
    always_comb begin
        ry_sel_c  = Ry_ARK;
        res_sel_c = Out_ARK;
        case (step_q)
            STEP_SBT: begin ry_sel_c = Ry_SBT; res_sel_c = Out_SBT; end
            STEP_SRW: begin ry_sel_c = Ry_SRW; res_sel_c = Out_SRW; end
            STEP_MXC: begin ry_sel_c = Ry_MXC; res_sel_c = Out_MXC; end
            default:  ;
        endcase
    end

    // Step order; the final round skips MixColumns
    always_comb begin
        step_nxt_c = STEP_SBT;
        fin_nxt_c  = 1'b0;
        case (step_q)
            STEP_SBT: step_nxt_c = STEP_SRW;
            STEP_SRW: step_nxt_c = (Round < RW'(LAST_ROUND)) ? STEP_MXC : STEP_ARK;
            STEP_MXC: step_nxt_c = STEP_ARK;
            STEP_ARK: begin
                if (Round < RW'(LAST_ROUND)) step_nxt_c = STEP_SBT;
                else                         fin_nxt_c  = 1'b1;
            end
            default:  step_nxt_c = STEP_SBT;
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        round_d = Round;
        st_d    = St_Out;
        rk_d    = Rk_ARK;
        ct_d    = Ct_Out;
        en_d    = en_q;
        busy_d  = Busy;
        done_d  = 1'b0;
        err_d   = Err;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (Start) begin
                    state_d = ST_ISSUE;
                    step_d  = STEP_ARK0;
                    round_d = '0;
                    st_d    = Pt_In;
                    rk_d    = Rk_In;
                    en_d    = en_of(STEP_ARK0);
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    wcnt_d  = '0;
                end
            end
            ST_ISSUE: begin
                // Round only settles to 0 on the Start edge, so keep tracking the key while issued
                if (is_ark(step_q)) rk_d = Rk_In;
                if (ry_sel_c) begin
                    st_d    = res_sel_c;
                    en_d    = '0;
                    state_d = ST_RELEASE;
                    wcnt_d  = '0;
                end else if (to_hit_c) begin
                    state_d = ST_ERR;
                    en_d    = '0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            ST_RELEASE: begin
                if (!ry_sel_c) begin
                    wcnt_d = '0;
                    if (fin_nxt_c) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_ISSUE;
                        step_d  = step_nxt_c;
                        en_d    = en_of(step_nxt_c);
                        if (step_nxt_c == STEP_SBT) round_d = Round + RW'(1);
                        if (is_ark(step_nxt_c))     rk_d    = Rk_In;
                    end
                end else if (to_hit_c) begin
                    state_d = ST_ERR;
                    en_d    = '0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            ST_FIN: begin
                ct_d    = St_Out;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            step_q  <= STEP_ARK0;
            Round   <= '0;
            St_Out  <= '0;
            Rk_ARK  <= '0;
            Ct_Out  <= '0;
            en_q    <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Err     <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            Round   <= round_d;
            St_Out  <= st_d;
            Rk_ARK  <= rk_d;
            Ct_Out  <= ct_d;
            en_q    <= en_d;
            Busy    <= busy_d;
            Done    <= done_d;
            Err     <= err_d;
            wcnt_q  <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES units and key table around the DUT,
// ciphertext scoreboard plus directed timing, timeout and reset checks.
module tb_aes_round_ctrl;

    localparam int unsigned TO_CYC = 255;
    localparam logic [127:0] FIPS_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         Start = 1'b0;
    logic [127:0] Pt_In = '0;
    logic [127:0] Rk_In;
    logic [3:0]   Round;
    logic [127:0] St_Out, Rk_ARK, Ct_Out;
    logic         En_SBT, En_SRW, En_MXC, En_ARK;
    logic         Ry_SBT, Ry_SRW, Ry_MXC, Ry_ARK;
    logic [127:0] Out_SBT, Out_SRW, Out_MXC, Out_ARK;
    logic         Busy, Done, Err;

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] sb_q[$];

    aes_round_ctrl #(.TO_CYC(TO_CYC)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Pt_In(Pt_In), .Rk_In(Rk_In),
        .Round(Round), .St_Out(St_Out), .Rk_ARK(Rk_ARK),
        .En_SBT(En_SBT), .En_SRW(En_SRW), .En_MXC(En_MXC), .En_ARK(En_ARK),
        .Ry_SBT(Ry_SBT), .Ry_SRW(Ry_SRW), .Ry_MXC(Ry_MXC), .Ry_ARK(Ry_ARK),
        .Out_SBT(Out_SBT), .Out_SRW(Out_SRW), .Out_MXC(Out_MXC), .Out_ARK(Out_ARK),
        .Ct_Out(Ct_Out), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    // ---------------- AES reference functions ----------------
    function automatic logic [127:0] rk_of(input int r);
        case (r)
            0:  return 128'h2b7e151628aed2a6abf7158809cf4f3c;
            1:  return 128'ha0fafe1788542cb123a339392a6c7605;
            2:  return 128'hf2c295f27a96b9435935807a7359f67f;
            3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
            5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:  return 128'head27321b58dbad2312bf5607f8d292f;
            9:  return 128'hac7766f319fadc2128d12941575c006e;
            10: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            default: return 128'h0;
        endcase
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = SBOX[2047 - 8*int'(s[127-8*i -: 8]) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-8*(4*c)   -: 8];
            a1 = s[127-8*(4*c+1) -: 8];
            a2 = s[127-8*(4*c+2) -: 8];
            a3 = s[127-8*(4*c+3) -: 8];
            o[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    // State after the first n of the 40 cipher steps
    function automatic logic [127:0] aes_steps(input logic [127:0] pt, input int n);
        logic [127:0] s;
        int k;
        s = pt;
        k = 0;
        if (n >= 1) begin s = s ^ rk_of(0); k = 1; end
        for (int r = 1; r <= 10; r++) begin
            if (k < n) begin s = sub_bytes(s);   k++; end
            if (k < n) begin s = shift_rows(s);  k++; end
            if (r < 10 && k < n) begin s = mix_columns(s); k++; end
            if (k < n) begin s = s ^ rk_of(r);   k++; end
        end
        return s;
    endfunction

    // ---------------- unit and key schedule models ----------------
    assign Rk_In   = rk_of(int'(Round));
    assign Out_SBT = sub_bytes(St_Out);
    assign Out_SRW = shift_rows(St_Out);
    assign Out_MXC = mix_columns(St_Out);
    assign Out_ARK = St_Out ^ Rk_ARK;

    logic [3:0]  en_now, ry_v;
    int unsigned tgt [4];
    int unsigned cnt [4];
    bit rand_mode = 1'b0;
    bit stall_mxc = 1'b0;

    assign en_now = {En_ARK, En_MXC, En_SRW, En_SBT};
    assign {Ry_ARK, Ry_MXC, Ry_SRW, Ry_SBT} = ry_v;

    // Ry follows En after tgt cycles; in random mode rise and fall are delayed
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ry_v <= '0;
            for (int i = 0; i < 4; i++) begin cnt[i] <= 0; tgt[i] <= 1; end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (en_now[i]) begin
                    if (!ry_v[i] && !(stall_mxc && i == 2 && Round == 4'd3)) begin
                        if (cnt[i] + 1 >= tgt[i]) ry_v[i] <= 1'b1;
                        else                      cnt[i] <= cnt[i] + 1;
                    end
                end else begin
                    cnt[i] <= 0;
                    tgt[i] <= rand_mode ? $urandom_range(20, 1) : 1;
                    if (!rand_mode || $urandom_range(3, 0) == 0) ry_v[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every Done must match the oldest queued ciphertext
    int done_cnt = 0;
    always @(negedge Clk) begin
        if (Rst && Done) begin
            done_cnt <= done_cnt + 1;
            check("done_expected", 128'(sb_q.size() != 0), 128'(1));
            if (sb_q.size() != 0) check("ct_out", Ct_Out, sb_q.pop_front());
        end
    end

    // Step monitor for the reference run
    bit           mon_on = 1'b0;
    logic [3:0]   en_prev = '0;
    int           en_rises = 0, onehot_viol = 0, mxc10_viol = 0;
    bit           sbt_in_got = 1'b0, sbt_out_got = 1'b0;
    logic [127:0] sbt_in = '0, sbt_out = '0;
    always @(negedge Clk) begin
        en_prev <= en_now;
        if (mon_on) begin
            en_rises <= en_rises + $countones(en_now & ~en_prev);
            if ($countones(en_now) > 1)   onehot_viol <= onehot_viol + 1;
            if (En_MXC && Round == 4'd10) mxc10_viol  <= mxc10_viol + 1;
            if (En_SBT && !en_prev[0] && !sbt_in_got) begin
                sbt_in <= St_Out; sbt_in_got <= 1'b1;
            end
            if (!En_SBT && en_prev[0] && !sbt_out_got) begin
                sbt_out <= St_Out; sbt_out_got <= 1'b1;
            end
        end
    end

    task automatic start_run(input logic [127:0] pt);
        @(negedge Clk);
        Pt_In = pt;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge Clk);
            if (Done) begin seen = 1'b1; break; end
        end
        check({name, "_done_seen"}, 128'(seen), 128'(1));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_round"},  128'(Round), 128'(0));
        check({name, "_st"},     St_Out,      128'(0));
        check({name, "_rk"},     Rk_ARK,      128'(0));
        check({name, "_ct"},     Ct_Out,      128'(0));
        check({name, "_en"},     128'(en_now), 128'(0));
        check({name, "_busy"},   128'(Busy),  128'(0));
        check({name, "_done"},   128'(Done),  128'(0));
        check({name, "_err"},    128'(Err),   128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_hi, done_edge, done_n, en_act, k, d0;
        bit busy_after, found;

        // 1: reset and idle
        repeat (3) @(negedge Clk);
        check_all_zero("reset");
        Rst = 1'b1;
        en_act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (en_now != 0 || Busy) en_act++;
        end
        check("idle_no_activity", 128'(en_act), 128'(0));
        check_all_zero("idle");

        // 2/3: FIPS-197 reference run with edge-accurate timing
        sb_q.push_back(FIPS_CT);
        mon_on = 1'b1;
        @(negedge Clk);
        Pt_In = FIPS_PT;
        Start = 1'b1;
        busy_hi = 0; done_edge = -1; done_n = 0; busy_after = 1'b1;
        for (int e = 0; e <= 170; e++) begin
            @(negedge Clk);
            if (e == 0) Start = 1'b0;
            if (e <= 160 && Busy) busy_hi++;
            if (e == 161) busy_after = Busy;
            if (Done) begin
                done_n++;
                if (done_edge < 0) done_edge = e;
            end
        end
        mon_on = 1'b0;
        check("done_edge",      128'(done_edge),  128'(161));
        check("done_pulses",    128'(done_n),     128'(1));
        check("busy_high",      128'(busy_hi),    128'(161));
        check("busy_after",     128'(busy_after), 128'(0));
        check("en_rises",       128'(en_rises),   128'(40));
        check("en_onehot",      128'(onehot_viol), 128'(0));
        check("mxc_round10",    128'(mxc10_viol), 128'(0));
        check("first_sbt_in",   sbt_in,  128'h193de3bea0f4e22b9ac68d2ae9f84808);
        check("first_sbt_out",  sbt_out, 128'hd42711aee0bf98f1b8b45de51e415230);
        check("round_hold",     128'(Round),      128'(10));
        check("ct_hold",        Ct_Out,           FIPS_CT);

        // 4: random unit latencies, Start pulsed mid-run
        rand_mode = 1'b1;
        sb_q.push_back(FIPS_CT);
        start_run(FIPS_PT);
        repeat (150) @(negedge Clk);
        Pt_In = PT2;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("busy_mid_run", 128'(Busy), 128'(1));
        wait_done("rand", 4000);
        rand_mode = 1'b0;
        repeat (5) @(negedge Clk);

        // 5: MixColumns stuck in round 3 -> timeout
        stall_mxc = 1'b1;
        d0 = done_cnt;
        start_run(PT2);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (En_MXC && Round == 4'd3) begin found = 1'b1; break; end
            @(negedge Clk);
        end
        check("mxc_r3_reached", 128'(found), 128'(1));
        k = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            k++;
            if (Err) break;
        end
        check("err_latency",  128'(k),      128'(TO_CYC));
        check("err_flag",     128'(Err),    128'(1));
        check("err_en",       128'(en_now), 128'(0));
        check("err_busy",     128'(Busy),   128'(0));
        check("err_st_hold",  St_Out,       aes_steps(PT2, 11));
        check("err_ct_hold",  Ct_Out,       FIPS_CT);
        repeat (20) @(negedge Clk);
        check("err_sticky",   128'(Err),    128'(1));
        check("err_no_done",  128'(done_cnt - d0), 128'(0));
        stall_mxc = 1'b0;
        sb_q.push_back(FIPS_CT);
        start_run(FIPS_PT);
        check("restart_err_clr", 128'(Err),  128'(0));
        check("restart_busy",    128'(Busy), 128'(1));
        wait_done("recover", 400);
        repeat (3) @(negedge Clk);

        // 6: asynchronous reset in round 5, then a clean run
        start_run(PT2);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (Round == 4'd5) begin found = 1'b1; break; end
        end
        check("round5_reached", 128'(found), 128'(1));
        d0 = done_cnt;
        #2;
        Rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst_no_done", 128'(done_cnt - d0), 128'(0));
        sb_q.push_back(aes_steps(PT2, 40));
        start_run(PT2);
        wait_done("after_rst", 400);
        repeat (3) @(negedge Clk);

        check("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
